// File: rtl/hash_unit_scheduler_pkg.sv
// Shared types and widths for the hash-unit nonce scheduler.
// Holds the scheduler state encoding and the result-FIFO entry layout.
package hash_unit_scheduler_pkg;

  localparam int NONCE_W    = 32;
  localparam int UNIT_IDX_W = 3;

  typedef enum logic [1:0] {
    SCHED_IDLE      = 2'd0,
    SCHED_RUN       = 2'd1,
    SCHED_EXHAUSTED = 2'd2,
    SCHED_DONE      = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [NONCE_W-1:0]    nonce;
    logic [UNIT_IDX_W-1:0] unit;
  } sol_entry_t;

endpackage

// File: rtl/hash_unit_scheduler_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after the pointer wins.
// The pointer moves to winner+1 only when the caller commits the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         M1_CLK,
  input  logic         RST,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             found;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt      = '0;
    win_idx  = ptr;
    scan_idx = '0;
    found    = 1'b0;
    // NOTE: blocking assignments here model the in-order priority scan; the
    // first hit sets found and shadows later ones within the same evaluation.
    for (int k = 0; k < N; k++) begin
      scan_idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[scan_idx]) begin
        found         = 1'b1;
        gnt[scan_idx] = 1'b1;
        win_idx       = scan_idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge M1_CLK) begin
    if (RST) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/hash_unit_scheduler.sv
// Nonce-range scheduler: hands fixed-size chunks to hash units round-robin and
// gathers their solutions through a second arbiter into a small result FIFO.
module hash_unit_scheduler
  import hash_unit_scheduler_pkg::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int CHUNK_LOG2 = 8,
  parameter int RES_DEPTH  = 4
) (
  input  logic                         M1_CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NONCE_W-1:0]           nonce_base,
  input  logic [NONCE_W-1:0]           nonce_limit,
  input  logic [NUM_UNITS-1:0]         unit_req,
  output logic [NUM_UNITS-1:0]         unit_grant,
  output logic [NONCE_W-1:0]           chunk_start,
  output logic [NONCE_W-1:0]           chunk_end,
  input  logic [NUM_UNITS-1:0]         sol_valid,
  input  logic [NONCE_W*NUM_UNITS-1:0] sol_nonce,
  output logic [NUM_UNITS-1:0]         sol_ack,
  output logic                         res_valid,
  output logic [NONCE_W-1:0]           res_nonce,
  output logic [UNIT_IDX_W-1:0]        res_unit,
  input  logic                         res_pop,
  output logic                         irq,
  output logic                         busy,
  output logic                         done
);

  localparam int               AW         = $clog2(RES_DEPTH);
  localparam logic [NONCE_W:0] CHUNK_SIZE = (NONCE_W + 1)'(1) << CHUNK_LOG2;
  localparam logic [NONCE_W:0] CHUNK_SPAN = CHUNK_SIZE - (NONCE_W + 1)'(1);

  // ---------------- dispatch ----------------
  sched_state_e         state, state_nxt;
  logic [NONCE_W:0]     next_nonce;
  logic [NONCE_W-1:0]   limit_q;
  logic [NONCE_W:0]     chunk_last;
  logic                 in_range;
  logic                 load_range;
  logic                 dispatch_go;
  logic                 done_nxt;
  logic [NUM_UNITS-1:0] disp_req;
  logic [NUM_UNITS-1:0] disp_gnt;

  // The 33-bit compare keeps a range ending at 0xFFFFFFFF from wrapping to 0.
  assign in_range    = next_nonce <= {1'b0, limit_q};
  assign chunk_last  = next_nonce + CHUNK_SPAN;
  assign dispatch_go = (state == SCHED_RUN) && in_range && !stop;
  assign load_range  = start && !stop && (state == SCHED_IDLE || state == SCHED_DONE);
  // A unit still showing req in its grant cycle must not be granted twice.
  assign disp_req    = unit_req & ~unit_grant;
  assign busy        = (state == SCHED_RUN) || (state == SCHED_EXHAUSTED);

  rr_arbiter #(.N(NUM_UNITS)) u_disp_arb (
    .M1_CLK  (M1_CLK),
    .RST     (RST),
    .req     (disp_req),
    .advance (dispatch_go),
    .gnt     (disp_gnt)
  );

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = SCHED_IDLE;
    end else begin
      case (state)
        SCHED_IDLE, SCHED_DONE:
          if (start) state_nxt = (nonce_base > nonce_limit) ? SCHED_EXHAUSTED : SCHED_RUN;
        SCHED_RUN:
          if (!in_range) state_nxt = SCHED_EXHAUSTED;
        SCHED_EXHAUSTED:
          if (&unit_req) state_nxt = SCHED_DONE;
        default:
          state_nxt = SCHED_IDLE;
      endcase
    end
    done_nxt = (state == SCHED_EXHAUSTED) && (state_nxt == SCHED_DONE);
  end

  always_ff @(posedge M1_CLK) begin
    if (RST) begin
      state       <= SCHED_IDLE;
      done        <= 1'b0;
      unit_grant  <= '0;
      chunk_start <= '0;
      chunk_end   <= '0;
      next_nonce  <= '0;
      limit_q     <= '0;
    end else begin
      state      <= state_nxt;
      done       <= done_nxt;
      unit_grant <= dispatch_go ? disp_gnt : '0;
      if (load_range) begin
        next_nonce <= {1'b0, nonce_base};
        limit_q    <= nonce_limit;
      end else if (dispatch_go && |disp_gnt) begin
        next_nonce  <= next_nonce + CHUNK_SIZE;
        chunk_start <= next_nonce[NONCE_W-1:0];
        chunk_end   <= (chunk_last > {1'b0, limit_q}) ? limit_q : chunk_last[NONCE_W-1:0];
      end
    end
  end

  // ---------------- solution collection ----------------
  sol_entry_t           mem [RES_DEPTH];
  sol_entry_t           push_entry;
  sol_entry_t           head_nxt;
  logic                 head_valid_nxt;
  logic [AW:0]          wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic                 fifo_empty, fifo_full;
  logic                 can_push, sol_take, do_pop;
  logic [NUM_UNITS-1:0] sol_gnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign can_push   = !fifo_full || res_pop;
  assign sol_take   = can_push && |sol_gnt;
  assign sol_ack    = can_push ? sol_gnt : '0;
  assign do_pop     = res_pop && !fifo_empty;
  assign wr_ptr_nxt = wr_ptr + (AW + 1)'(sol_take);
  assign rd_ptr_nxt = rd_ptr + (AW + 1)'(do_pop);
  assign irq        = res_valid;

  rr_arbiter #(.N(NUM_UNITS)) u_sol_arb (
    .M1_CLK  (M1_CLK),
    .RST     (RST),
    .req     (sol_valid),
    .advance (sol_take),
    .gnt     (sol_gnt)
  );

  always_comb begin
    push_entry = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sol_gnt[i]) begin
        push_entry = '{nonce: sol_nonce[NONCE_W*i +: NONCE_W], unit: UNIT_IDX_W'(i)};
      end
    end
  end

  // The head register is fed from the entry being pushed when it lands in an
  // otherwise-empty slot at the read pointer, so res_* stay registered.
  always_comb begin
    head_nxt       = '0;
    head_valid_nxt = 1'b0;
    if (rd_ptr_nxt != wr_ptr_nxt) begin
      head_valid_nxt = 1'b1;
      if (rd_ptr_nxt == wr_ptr) head_nxt = push_entry;
      else                      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers,
  // which keeps the array free of reset fan-out.
  always_ff @(posedge M1_CLK) begin
    if (sol_take) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge M1_CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      res_valid <= 1'b0;
      res_nonce <= '0;
      res_unit  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      res_valid <= head_valid_nxt;
      res_nonce <= head_nxt.nonce;
      res_unit  <= head_nxt.unit;
    end
  end

endmodule
